// File: rtl/alu_simd_pkg.sv
// Shared definitions for the SIMD ALU result bus.
//   - USE_SIMD mode encoding
//   - fixed 8-segment map of the 45-bit S word (LSB / width per segment)
//   - lanes_per_mode: lanes carried by one word in a given mode
package alu_simd_pkg;

  localparam int SIMD_W  = 45;
  localparam int NUM_SEG = 8;
  localparam int CARRY_W = 2 * NUM_SEG;

  typedef enum logic [1:0] {
    MODE_27x18   = 2'b00,
    MODE_SUM_9x9 = 2'b01,
    MODE_SUM_4x4 = 2'b10,
    MODE_SUM_2x2 = 2'b11
  } simd_mode_e;

  typedef logic [5:0] bitpos_t;

  // Segment LSB positions within S.
  function automatic bitpos_t seg_lsb(input logic [2:0] k);
    case (k)
      3'd0:    seg_lsb = 6'd0;
      3'd1:    seg_lsb = 6'd13;
      3'd2:    seg_lsb = 6'd17;
      3'd3:    seg_lsb = 6'd23;
      3'd4:    seg_lsb = 6'd27;
      3'd5:    seg_lsb = 6'd31;
      3'd6:    seg_lsb = 6'd35;
      default: seg_lsb = 6'd41;
    endcase
  endfunction

  // Segment widths in bits.
  function automatic bitpos_t seg_width(input logic [2:0] k);
    case (k)
      3'd0:    seg_width = 6'd13;
      3'd2,
      3'd6:    seg_width = 6'd6;
      default: seg_width = 6'd4;
    endcase
  endfunction

  function automatic logic [3:0] lanes_per_mode(input simd_mode_e m);
    case (m)
      MODE_27x18:   lanes_per_mode = 4'd1;
      MODE_SUM_9x9: lanes_per_mode = 4'd2;
      MODE_SUM_4x4: lanes_per_mode = 4'd4;
      default:      lanes_per_mode = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/alu_simd_lane_extract.sv
// Combinational lane slicer for one captured ALU result word.
// Ports:
//   word       in   captured S word
//   carry      in   captured segment carry vector, seg k at [2k+1:2k]
//   mode       in   captured USE_SIMD mode
//   lane_idx   in   lane to extract, 0 = least-significant
//   data       out  lane value, sign- or zero-extended to DATA_W
//   lane_carry out  carry pair of the lane's highest segment
//   last       out  lane_idx is the final lane for this mode
module alu_simd_lane_extract
  import alu_simd_pkg::*;
#(
  parameter bit SIGNED_EXT = 1'b1,
  parameter int DATA_W     = SIMD_W
) (
  input  logic [DATA_W-1:0]  word,
  input  logic [CARRY_W-1:0] carry,
  input  simd_mode_e         mode,
  input  logic [2:0]         lane_idx,
  output logic [DATA_W-1:0]  data,
  output logic [1:0]         lane_carry,
  output logic               last
);

  logic [2:0]        first_seg, top_seg;
  bitpos_t           lo, width;
  logic [DATA_W-1:0] shifted, mask;
  logic              msb;

  always_comb begin
    // Lanes are always groups of whole, aligned segments, so the segment
    // range falls straight out of the lane index bits.
    first_seg = 3'd0;
    top_seg   = 3'd7;
    case (mode)
      MODE_27x18:   begin first_seg = 3'd0;                  top_seg = 3'd7;                  end
      MODE_SUM_9x9: begin first_seg = {lane_idx[0], 2'b00};  top_seg = {lane_idx[0], 2'b11};  end
      MODE_SUM_4x4: begin first_seg = {lane_idx[1:0], 1'b0}; top_seg = {lane_idx[1:0], 1'b1}; end
      default:      begin first_seg = lane_idx;              top_seg = lane_idx;              end
    endcase

    lo      = seg_lsb(first_seg);
    width   = seg_lsb(top_seg) + seg_width(top_seg) - lo;
    shifted = word >> lo;
    // A full 45-bit lane shifts every one out, leaving an all-ones mask.
    mask    = ~({DATA_W{1'b1}} << width);
    msb     = shifted[width - 6'd1];

    if (SIGNED_EXT && msb) data = shifted | ~mask;
    else                   data = shifted & mask;

    lane_carry = carry[{top_seg, 1'b0} +: 2];
    last       = ({1'b0, lane_idx} == (lanes_per_mode(mode) - 4'd1));
  end

endmodule

// File: rtl/alu_simd_result_unpacker.sv
// Consumer side of the 45-bit SIMD ALU result bus. Captures one result word
// with its segment carries and mode, then streams the 1/2/4/8 extended lanes
// out one per handshake.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   word handshake
//   in_use_simd         mode of the offered word
//   in_s, in_carry      result word and segment carry vector
//   out_valid/out_ready lane handshake
//   out_data            extended lane value
//   out_carry           carry pair of the lane's top segment
//   out_idx, out_last   lane index and final-lane flag
module alu_simd_result_unpacker
  import alu_simd_pkg::*;
#(
  parameter bit SIGNED_EXT = 1'b1,
  parameter int DATA_W     = SIMD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_use_simd,
  input  logic [DATA_W-1:0]  in_s,
  input  logic [CARRY_W-1:0] in_carry,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         out_carry,
  output logic [2:0]         out_idx,
  output logic               out_last
);

  typedef enum logic {ST_IDLE, ST_EMIT} state_e;

  state_e             state_q;
  logic [2:0]         lane_q;
  logic [DATA_W-1:0]  word_q;
  logic [CARRY_W-1:0] carry_q;
  simd_mode_e         mode_q;

  logic [DATA_W-1:0]  lane_data;
  logic [1:0]         lane_carry;
  logic               lane_last;
  logic               accept, lane_fire;

  alu_simd_lane_extract #(
    .SIGNED_EXT (SIGNED_EXT),
    .DATA_W     (DATA_W)
  ) u_extract (
    .word       (word_q),
    .carry      (carry_q),
    .mode       (mode_q),
    .lane_idx   (lane_q),
    .data       (lane_data),
    .lane_carry (lane_carry),
    .last       (lane_last)
  );

  assign out_valid = (state_q == ST_EMIT);
  // The final lane's handshake frees the capture registers in the same
  // cycle, so the next word can land without an idle bubble.
  assign in_ready  = ~reset & (~out_valid | (out_ready & lane_last));
  assign accept    = in_valid & in_ready;
  assign lane_fire = out_valid & out_ready;

  assign out_data  = out_valid ? lane_data  : '0;
  assign out_carry = out_valid ? lane_carry : 2'b00;
  assign out_idx   = out_valid ? lane_q     : 3'd0;
  assign out_last  = out_valid & lane_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lane_q  <= 3'd0;
      word_q  <= '0;
      carry_q <= '0;
      mode_q  <= MODE_27x18;
    end else if (accept) begin
      state_q <= ST_EMIT;
      lane_q  <= 3'd0;
      word_q  <= in_s;
      carry_q <= in_carry;
      mode_q  <= simd_mode_e'(in_use_simd);
    end else if (lane_fire) begin
      if (lane_last) begin
        state_q <= ST_IDLE;
        lane_q  <= 3'd0;
      end else begin
        lane_q  <= lane_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_simd_result_unpacker.sv
// Bench for alu_simd_result_unpacker: a sign-extending and a zero-extending
// instance share all inputs; each lane is compared with a bit-level model of
// the segment map.
module tb_alu_simd_result_unpacker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_use_simd = 2'b00;
  logic [44:0] in_s = '0;
  logic [15:0] in_carry = '0;
  logic        out_ready = 1'b0;

  logic        in_ready_s, out_valid_s, out_last_s;
  logic [44:0] out_data_s;
  logic [1:0]  out_carry_s;
  logic [2:0]  out_idx_s;
  logic        in_ready_z, out_valid_z, out_last_z;
  logic [44:0] out_data_z;
  logic [1:0]  out_carry_z;
  logic [2:0]  out_idx_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_simd_result_unpacker #(.SIGNED_EXT(1'b1), .DATA_W(45)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_use_simd(in_use_simd), .in_s(in_s), .in_carry(in_carry),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_carry(out_carry_s), .out_idx(out_idx_s), .out_last(out_last_s));

  alu_simd_result_unpacker #(.SIGNED_EXT(1'b0), .DATA_W(45)) dut_z (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_z),
    .in_use_simd(in_use_simd), .in_s(in_s), .in_carry(in_carry),
    .out_valid(out_valid_z), .out_ready(out_ready), .out_data(out_data_z),
    .out_carry(out_carry_z), .out_idx(out_idx_z), .out_last(out_last_z));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model: lane boundaries from the segment table ----
  function automatic int n_lanes(input logic [1:0] m);
    return 1 << m;
  endfunction

  function automatic int top_seg(input logic [1:0] m, input int k);
    int per;
    per = 8 / n_lanes(m);
    return k * per + per - 1;
  endfunction

  function automatic logic [44:0] model_data(input logic [1:0] m, input logic [44:0] s,
                                             input int k, input bit sext);
    int seg_lo [8] = '{0, 13, 17, 23, 27, 31, 35, 41};
    int seg_w  [8] = '{13, 4, 6, 4, 4, 4, 6, 4};
    int per, lo, hi;
    logic [44:0] v;
    per = 8 / n_lanes(m);
    lo  = seg_lo[k * per];
    hi  = seg_lo[top_seg(m, k)] + seg_w[top_seg(m, k)] - 1;
    v   = '0;
    for (int b = 0; b < 45; b++) begin
      if (b + lo <= hi)  v[b] = s[b + lo];
      else if (sext)     v[b] = s[hi];
    end
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_lane(input logic [1:0] m, input logic [44:0] s, input logic [15:0] c,
                            input int k);
    int ts;
    ts = top_seg(m, k);
    chk("valid_s", 64'(out_valid_s), 64'd1);
    chk("valid_z", 64'(out_valid_z), 64'd1);
    chk("data_s",  64'(out_data_s),  64'(model_data(m, s, k, 1'b1)));
    chk("data_z",  64'(out_data_z),  64'(model_data(m, s, k, 1'b0)));
    chk("carry_s", 64'(out_carry_s), 64'((c >> (2 * ts)) & 16'h3));
    chk("carry_z", 64'(out_carry_z), 64'((c >> (2 * ts)) & 16'h3));
    chk("idx",     64'(out_idx_s),   64'(k));
    chk("last",    64'(out_last_s),  64'(k == n_lanes(m) - 1));
  endtask

  // Offer a word from IDLE; afterwards lane 0 must be on the bus.
  task automatic start_word(input logic [1:0] m, input logic [44:0] s, input logic [15:0] c);
    in_valid = 1'b1; in_use_simd = m; in_s = s; in_carry = c;
    out_ready = 1'($urandom);
    #1;
    chk("idle_in_ready", 64'(in_ready_s), 64'd1);
    chk("idle_out_valid", 64'(out_valid_s), 64'd0);
    chk("idle_out_data", 64'(out_data_z), 64'd0);
    tick;
    in_valid = 1'b0;
  endtask

  // Drain all lanes of a captured word. stall_kind: 0 none, 1 ready 1,0,0,1
  // pattern (two-cycle stall on odd lanes), 2 random. hold_mode >= 0 drives
  // in_use_simd to that value during emission, else random garbage.
  task automatic emit_word(input logic [1:0] m, input logic [44:0] s, input logic [15:0] c,
                           input int stall_kind, input int hold_mode, input bit chain,
                           input logic [1:0] nm, input logic [44:0] ns, input logic [15:0] nc);
    int n, st;
    n = n_lanes(m);
    for (int k = 0; k < n; k++) begin
      case (stall_kind)
        0:       st = 0;
        1:       st = (k % 2 == 1) ? 2 : 0;
        default: st = int'($urandom_range(0, 2));
      endcase
      for (int j = 0; j <= st; j++) begin
        out_ready   = (j == st);
        in_use_simd = (hold_mode >= 0) ? 2'(hold_mode) : 2'($urandom);
        in_s        = {13'($urandom), $urandom};
        in_valid    = 1'b0;
        if (j == st && k == n - 1 && chain) begin
          in_valid = 1'b1; in_use_simd = nm; in_s = ns; in_carry = nc;
        end
        #1;
        check_lane(m, s, c, k);
        chk("emit_in_ready", 64'(in_ready_s), 64'(j == st && k == n - 1));
        tick;
      end
    end
    in_valid = 1'b0;
    if (!chain) begin
      chk("post_out_valid_s", 64'(out_valid_s), 64'd0);
      chk("post_out_valid_z", 64'(out_valid_z), 64'd0);
      chk("post_out_last", 64'(out_last_s), 64'd0);
    end
  endtask

  initial begin
    logic [1:0]  m, nm;
    logic [44:0] s, ns;
    logic [15:0] c, nc;

    // Reset state
    reset = 1'b1;
    in_valid = 1'b1;  // must not be captured
    tick;
    chk("rst_in_ready", 64'(in_ready_s), 64'd0);
    chk("rst_out_valid", 64'(out_valid_s), 64'd0);
    chk("rst_out_data", 64'(out_data_s), 64'd0);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready_s), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid_s), 64'd0);

    // 1: single 45-bit lane, MSB set
    s = 45'h1FFF_FFFF_FFFF; c = 16'h8123;
    start_word(2'b00, s, c);
    chk("t1_carry", 64'(out_carry_s), 64'd2);
    chk("t1_data", 64'(out_data_s), 64'(s));
    emit_word(2'b00, s, c, 0, -1, 1'b0, 2'b00, '0, '0);

    // 2: two lanes, upper one negative
    s = {18'h2_0001, 27'h000_0005}; c = 16'h4321;
    start_word(2'b01, s, c);
    chk("t2_l0", 64'(out_data_s), 64'h5);
    emit_word(2'b01, s, c, 0, -1, 1'b0, 2'b00, '0, '0);

    // 3: eight lanes, zero-extension case
    s = '0; s[12:0] = 13'h1000; s[16:13] = 4'h7; c = 16'hA5C3;
    start_word(2'b11, s, c);
    chk("t3_l0_z", 64'(out_data_z), 64'h1000);
    emit_word(2'b11, s, c, 0, -1, 1'b0, 2'b00, '0, '0);

    // 4: mode 10 with stalls, chained into a mode 01 word
    s = {13'($urandom), $urandom}; c = 16'($urandom);
    ns = {13'($urandom), $urandom}; nc = 16'($urandom);
    start_word(2'b10, s, c);
    emit_word(2'b10, s, c, 1, -1, 1'b1, 2'b01, ns, nc);
    emit_word(2'b01, ns, nc, 0, -1, 1'b0, 2'b00, '0, '0);

    // 5: reset in the middle of a mode 11 word
    s = {13'($urandom), $urandom}; c = 16'($urandom);
    start_word(2'b11, s, c);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1; check_lane(2'b11, s, c, k); tick;
    end
    check_lane(2'b11, s, c, 3);
    reset = 1'b1; in_valid = 1'b1;
    #1;
    chk("t5_ready_in_rst", 64'(in_ready_s), 64'd0);
    tick;
    chk("t5_out_valid", 64'(out_valid_s), 64'd0);
    chk("t5_out_data", 64'(out_data_s), 64'd0);
    in_valid = 1'b0; reset = 1'b0;
    #1;
    chk("t5_in_ready", 64'(in_ready_s), 64'd1);
    tick;
    chk("t5_no_capture", 64'(out_valid_s), 64'd0);
    s = {13'($urandom), $urandom}; c = 16'($urandom);
    start_word(2'b00, s, c);
    emit_word(2'b00, s, c, 0, -1, 1'b0, 2'b00, '0, '0);

    // 6: mode input flips to 11 during a mode 10 word
    s = {13'($urandom), $urandom}; c = 16'($urandom);
    start_word(2'b10, s, c);
    emit_word(2'b10, s, c, 2, 3, 1'b0, 2'b00, '0, '0);

    // Random words, random stalls, random chaining
    m = 2'($urandom); s = {13'($urandom), $urandom}; c = 16'($urandom);
    start_word(m, s, c);
    for (int w = 0; w < 30; w++) begin
      bit ch;
      ch = (w < 29) && 1'($urandom);
      nm = 2'($urandom); ns = {13'($urandom), $urandom}; nc = 16'($urandom);
      emit_word(m, s, c, 2, -1, ch, nm, ns, nc);
      if (ch) begin
        m = nm; s = ns; c = nc;
      end else if (w < 29) begin
        m = 2'($urandom); s = {13'($urandom), $urandom}; c = 16'($urandom);
        start_word(m, s, c);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
